// File: rtl/hazard_ctrl_if.sv
// IF/ID sequencer bus: ID/EX status in, PC/IF_ID/ID_EX control out.
// master drives the status side, slave is the sequencer itself.
interface hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic              ex_is_load;
  logic [REG_AW-1:0] ex_rd;
  logic              branch_taken;
  logic              mdiv_start;
  logic              mdiv_done;
  logic              pc_en;
  logic              if_id_locker;
  logic              if_id_flush;
  logic              id_ex_bubble;
  logic              id_ex_hold;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
  logic              proto_err;

  modport master (
    output id_rs1, id_rs2,
    output id_use_rs1, id_use_rs2,
    output ex_is_load, ex_rd,
    output branch_taken,
    output mdiv_start, mdiv_done,
    input  pc_en, if_id_locker,
    input  if_id_flush,
    input  id_ex_bubble, id_ex_hold,
    input  stall_cnt, flush_cnt,
    input  proto_err
  );

  modport slave (
    input  id_rs1, id_rs2,
    input  id_use_rs1, id_use_rs2,
    input  ex_is_load, ex_rd,
    input  branch_taken,
    input  mdiv_start, mdiv_done,
    output pc_en, if_id_locker,
    output if_id_flush,
    output id_ex_bubble, id_ex_hold,
    output stall_cnt, flush_cnt,
    output proto_err
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Mealy sequencer for PC / IF_ID: load-use stall, branch flush, mul/div wait.
// Also keeps saturating stall/flush counters and a sticky protocol error.
module hazard_ctrl #(
  parameter int REG_AW      = 5,
  parameter int FLUSH_DEPTH = 1,
  parameter int CNT_W       = 16
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    MDIV  = 2'd2
  } state_e;

  localparam int FW = 3;
  localparam logic [FW-1:0] FL_LOAD =
    FW'(FLUSH_DEPTH - 1);
  localparam bit MULTI_FL = FLUSH_DEPTH > 1;

  state_e           state_q, state_d;
  logic [FW-1:0]    fcnt_q, fcnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             err_q, err_d;

  logic [REG_AW-1:0] rs1, rs2, rd;
  logic rs1_hit, rs2_hit, lu;
  logic pc_en, locker, flush;
  logic bubble, hold;
  logic br_acc, err_set;

  assign rs1 = bus.id_rs1;
  assign rs2 = bus.id_rs2;
  assign rd  = bus.ex_rd;

  assign rs1_hit = bus.id_use_rs1 && (rs1 == rd);
  assign rs2_hit = bus.id_use_rs2 && (rs2 == rd);
  assign lu = bus.ex_is_load && (rd != '0)
           && (rs1_hit || rs2_hit);

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    pc_en   = 1'b1;
    locker  = 1'b1;
    flush   = 1'b0;
    bubble  = 1'b0;
    hold    = 1'b0;
    br_acc  = 1'b0;
    err_set = 1'b0;
    unique case (state_q)
      RUN: begin
        err_set = bus.mdiv_done
               || (bus.branch_taken
                   && bus.mdiv_start);
        if (bus.branch_taken) begin
          locker = 1'b0;
          flush  = 1'b1;
          bubble = 1'b1;
          br_acc = 1'b1;
          fcnt_d = FL_LOAD;
          if (MULTI_FL) state_d = FLUSH;
        end else if (bus.mdiv_start) begin
          pc_en   = 1'b0;
          locker  = 1'b0;
          hold    = 1'b1;
          state_d = MDIV;
        end else if (lu) begin
          pc_en  = 1'b0;
          locker = 1'b0;
          bubble = 1'b1;
        end
      end
      FLUSH: begin
        locker  = 1'b0;
        flush   = 1'b1;
        bubble  = 1'b1;
        err_set = bus.mdiv_done;
        fcnt_d  = fcnt_q - FW'(1);
        if (fcnt_q <= FW'(1)) state_d = RUN;
      end
      MDIV: begin
        err_set = bus.branch_taken
               || bus.mdiv_start;
        if (!bus.mdiv_done) begin
          pc_en  = 1'b0;
          locker = 1'b0;
          hold   = 1'b1;
        end else begin
          state_d = RUN;
          if (lu) begin
            pc_en  = 1'b0;
            locker = 1'b0;
            bubble = 1'b1;
          end
        end
      end
      default: state_d = RUN;
    endcase
    // reset overrides everything, including the FSM
    if (reset) begin
      state_d = RUN;
      fcnt_d  = '0;
      pc_en   = 1'b0;
      locker  = 1'b0;
      flush   = 1'b1;
      bubble  = 1'b1;
      hold    = 1'b0;
      br_acc  = 1'b0;
      err_set = 1'b0;
    end
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    err_d   = err_q | err_set;
    if (!pc_en && (stall_q != '1))
      stall_d = stall_q + CNT_W'(1);
    if (br_acc && (flush_q != '1))
      flush_d = flush_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      fcnt_q  <= '0;
      stall_q <= '0;
      flush_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
      err_q   <= err_d;
    end
  end

  assign bus.pc_en        = pc_en;
  assign bus.if_id_locker = locker;
  assign bus.if_id_flush  = flush;
  assign bus.id_ex_bubble = bubble;
  assign bus.id_ex_hold   = hold;
  assign bus.stall_cnt    = stall_q;
  assign bus.flush_cnt    = flush_q;
  assign bus.proto_err    = err_q;
endmodule
